// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response, redirect and decode handoff.
interface fetch_prefetch_unit_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] instr_mem_addr_o;
  logic              instr_mem_rd_o;
  logic              instr_mem_ready_i;
  logic [31:0]       instr_mem_data_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_addr_i;
  logic              instr_valid_o;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] instr_addr_o;
  logic              instr_ready_i;
  logic [CntW-1:0]   count_o;
  logic              misaligned_o;

  modport master (
    output instr_mem_addr_o, instr_mem_rd_o, instr_valid_o, instr_o, instr_addr_o,
           count_o, misaligned_o,
    input  instr_mem_ready_i, instr_mem_data_i, redirect_i, redirect_addr_i, instr_ready_i
  );

  modport slave (
    input  instr_mem_addr_o, instr_mem_rd_o, instr_valid_o, instr_o, instr_addr_o,
           count_o, misaligned_o,
    output instr_mem_ready_i, instr_mem_data_i, redirect_i, redirect_addr_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: sequential PC fetch into a small FIFO, flushed on redirect,
// halted by a sticky misaligned-target flag.
module fetch_prefetch_unit #(
  parameter int unsigned          DEPTH      = 4,
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = '0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fetch_prefetch_unit_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              mis_q, mis_d;

  logic [31:0]       data_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];

  logic rd, valid, push, pop;

  // rst_i gates the request so it stays low throughout reset, not just after the first edge.
  assign rd    = (count_q < CntW'(DEPTH)) & ~bus.redirect_i & ~mis_q & ~rst_i;
  assign valid = (count_q != '0) & ~bus.redirect_i;
  assign push  = rd & bus.instr_mem_ready_i;
  assign pop   = valid & bus.instr_ready_i;

  assign bus.instr_mem_addr_o = pc_q;
  assign bus.instr_mem_rd_o   = rd;
  assign bus.instr_valid_o    = valid;
  assign bus.instr_o          = data_mem_q[rd_ptr_q];
  assign bus.instr_addr_o     = addr_mem_q[rd_ptr_q];
  assign bus.count_o          = count_q;
  assign bus.misaligned_o     = mis_q;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mis_d    = mis_q;
    if (bus.redirect_i) begin
      pc_d     = bus.redirect_addr_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      mis_d    = |bus.redirect_addr_i[1:0];
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_ADDR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mis_q    <= mis_d;
    end
  end

  // Storage is write-only-on-push and needs no reset; count_q guards every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus.instr_mem_data_i;
      addr_mem_q[wr_ptr_q] <= pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit (DEPTH=4, RESET_ADDR=0); memory returns ~addr.
module tb_fetch_prefetch_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_addr;

  fetch_prefetch_unit_if #(.DEPTH(4), .ADDR_W(32)) bus ();

  fetch_prefetch_unit #(.DEPTH(4), .ADDR_W(32), .RESET_ADDR(32'h0)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: word at address A is ~A.
  always_comb bus.instr_mem_data_i = ~bus.instr_mem_addr_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.instr_mem_ready_i = 1'b1;
    bus.instr_ready_i     = 1'b0;
    bus.redirect_i        = 1'b0;
    bus.redirect_addr_i   = 32'h0;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_rd", 32'(bus.instr_mem_rd_o), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_mis", 32'(bus.misaligned_o), 32'd0);
    chk("rst_pc", bus.instr_mem_addr_o, 32'h0);
    step();
    step();
    chk("rst_rd_clk", 32'(bus.instr_mem_rd_o), 32'd0);
    #3 rst_i = 1'b0;
    #1;
    chk("rel_rd", 32'(bus.instr_mem_rd_o), 32'd1);
    chk("rel_pc", bus.instr_mem_addr_o, 32'h0);

    // Fill with decode stalled.
    step();
    chk("fill1_count", 32'(bus.count_o), 32'd1);
    chk("fill1_valid", 32'(bus.instr_valid_o), 32'd1);
    chk("fill1_head", bus.instr_addr_o, 32'h0);
    chk("fill1_instr", bus.instr_o, 32'hFFFF_FFFF);
    step();
    step();
    step();
    chk("full_count", 32'(bus.count_o), 32'd4);
    chk("full_rd", 32'(bus.instr_mem_rd_o), 32'd0);
    chk("full_pc", bus.instr_mem_addr_o, 32'h10);
    chk("full_head", bus.instr_addr_o, 32'h0);
    step();
    chk("full_hold", 32'(bus.count_o), 32'd4);

    // Continuous drain with concurrent refill, through pointer wrap.
    bus.instr_ready_i = 1'b1;
    exp_addr = 32'h0;
    #1;
    chk("full_pop_rd", 32'(bus.instr_mem_rd_o), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("drain_valid", 32'(bus.instr_valid_o), 32'd1);
      chk("drain_addr", bus.instr_addr_o, exp_addr);
      chk("drain_instr", bus.instr_o, ~exp_addr);
      chk("drain_cnt_ok", 32'((bus.count_o == 3'd3) || (bus.count_o == 3'd4)), 32'd1);
      exp_addr = exp_addr + 32'h4;
      step();
    end

    // Bring occupancy to 2, then redirect to 0x100.
    bus.instr_mem_ready_i = 1'b0;
    step();
    bus.instr_ready_i     = 1'b0;
    bus.instr_mem_ready_i = 1'b1;
    #1;
    chk("pre_redir_count", 32'(bus.count_o), 32'd2);
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h100;
    #1;
    chk("redir_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("redir_rd", 32'(bus.instr_mem_rd_o), 32'd0);
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("post_redir_count", 32'(bus.count_o), 32'd0);
    chk("post_redir_pc", bus.instr_mem_addr_o, 32'h100);
    chk("post_redir_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("post_redir_rd", 32'(bus.instr_mem_rd_o), 32'd1);
    step();
    chk("redir_head_valid", 32'(bus.instr_valid_o), 32'd1);
    chk("redir_head_addr", bus.instr_addr_o, 32'h100);
    chk("redir_head_instr", bus.instr_o, ~32'h100);

    // Misaligned target halts fetch until an aligned redirect.
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h102;
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("mis_set", 32'(bus.misaligned_o), 32'd1);
    chk("mis_rd", 32'(bus.instr_mem_rd_o), 32'd0);
    chk("mis_count", 32'(bus.count_o), 32'd0);
    step();
    step();
    step();
    chk("mis_sticky", 32'(bus.misaligned_o), 32'd1);
    chk("mis_rd_hold", 32'(bus.instr_mem_rd_o), 32'd0);
    chk("mis_cnt_hold", 32'(bus.count_o), 32'd0);
    chk("mis_valid", 32'(bus.instr_valid_o), 32'd0);
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h200;
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("mis_clear", 32'(bus.misaligned_o), 32'd0);
    chk("resume_pc", bus.instr_mem_addr_o, 32'h200);
    chk("resume_rd", 32'(bus.instr_mem_rd_o), 32'd1);
    step();
    chk("resume_head", bus.instr_addr_o, 32'h200);

    // Asynchronous reset mid-stream with three entries queued.
    step();
    step();
    chk("pre_rst_count", 32'(bus.count_o), 32'd3);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count_o), 32'd0);
    chk("arst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("arst_rd", 32'(bus.instr_mem_rd_o), 32'd0);
    chk("arst_pc", bus.instr_mem_addr_o, 32'h0);
    #1 rst_i = 1'b0;
    #1;
    chk("arst_rel_rd", 32'(bus.instr_mem_rd_o), 32'd1);
    chk("arst_rel_pc", bus.instr_mem_addr_o, 32'h0);
    step();
    chk("arst_head", bus.instr_addr_o, 32'h0);

    // Random backpressure on both sides; consumed stream must be 0,4,8,...
    exp_addr = 32'h0;
    for (int i = 0; i < 1000; i++) begin
      bus.instr_mem_ready_i = 1'($urandom_range(0, 1));
      bus.instr_ready_i     = 1'($urandom_range(0, 1));
      #1;
      chk("rand_cnt_max", 32'(bus.count_o <= 3'd4), 32'd1);
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        chk("rand_addr", bus.instr_addr_o, exp_addr);
        chk("rand_instr", bus.instr_o, ~exp_addr);
        exp_addr = exp_addr + 32'h4;
      end
      step();
    end
    chk("rand_progress", 32'(exp_addr > 32'h100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-003 SHALL have parameter RESET_ADDR, default 0, first fetch address after reset; word aligned.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 instr_mem_addr_o  output  ADDR_W  fetch address.
REQ-008 instr_mem_rd_o  output  1  fetch request.
REQ-009 instr_mem_ready_i  input  1  memory accepts request; data valid same cycle.
REQ-010 instr_mem_data_i  input  32  instruction word returned.
REQ-011 redirect_i  input  1  flush and restart fetch (branch/jump taken).
REQ-012 redirect_addr_i  input  ADDR_W  restart address.
REQ-013 instr_valid_o  output  1  queue head valid.
REQ-014 instr_o  output  32  queue head instruction.
REQ-015 instr_addr_o  output  ADDR_W  queue head address.
REQ-016 instr_ready_i  input  1  decode consumes head.
REQ-017 count_o  output  clog2(DEPTH)+1  queue occupancy.
REQ-018 misaligned_o  output  1  sticky fetch-address-misaligned flag.

Function
REQ-019 SHALL hold fetch PC register; instr_mem_addr_o equals PC at all times.
REQ-020 instr_mem_rd_o SHALL be 1 iff count_o < DEPTH, redirect_i = 0 and misaligned_o = 0; no combinational dependence on instr_ready_i or instr_mem_ready_i.
REQ-021 Push SHALL occur when instr_mem_rd_o & instr_mem_ready_i: store {instr_mem_data_i, PC} at write pointer; PC <= PC + 4 (mod 2^ADDR_W).
REQ-022 Pop SHALL occur when instr_valid_o & instr_ready_i; read pointer advances.
REQ-023 Pointers SHALL wrap modulo DEPTH; count_o SHALL be +1 on push only, -1 on pop only, unchanged on both.
REQ-024 instr_valid_o SHALL be (count_o != 0) & ~redirect_i; instr_o/instr_addr_o driven from head entry, no bypass: pushed word visible one cycle after push.
REQ-025 instr_mem_ready_i = 0 SHALL stall fetch; PC, pointers unchanged except for pops.
REQ-026 On redirect_i = 1: no push, no pop that cycle; next cycle count_o = 0, pointers reset, PC = redirect_addr_i.
REQ-027 If redirect_addr_i[1:0] != 0 on redirect, misaligned_o SHALL go 1 next cycle and stay 1; fetch halts (rd 0), queue stays empty.
REQ-028 misaligned_o SHALL clear only on a later redirect with aligned address, or reset.
REQ-029 Full queue with simultaneous pop: no push that cycle (rd low); push resumes next cycle.
REQ-030 instr_o/instr_addr_o SHALL be don't-care when instr_valid_o = 0.

Reset
REQ-031 While rst_i = 1: PC = RESET_ADDR, count_o = 0, pointers 0, instr_valid_o = 0, instr_mem_rd_o = 0, misaligned_o = 0, regardless of clock.
REQ-032 rst_i asserted mid-operation SHALL discard queue contents immediately; first cycle after deassertion instr_mem_rd_o = 1 with address RESET_ADDR.
REQ-033 Queue storage contents SHALL not require reset.

Verification (DEPTH=4, RESET_ADDR=0)
REQ-034 Reset released, ready_i=1, instr_ready_i=0 -> pushes at addr 0x0,0x4,0x8,0xC; count_o 4; rd_o 0; PC 0x10; instr_valid_o from cycle 2, head addr 0x0.
REQ-035 Full queue, then instr_ready_i=1 continuously -> one pop per cycle, in-order addrs 0x0,0x4,...; count_o stays 3-4; no lost or duplicated word over 20 cycles incl. pointer wrap.
REQ-036 count_o=2, redirect_i=1 addr 0x100 -> that cycle instr_valid_o 0, rd_o 0; next cycle count_o 0, addr_o 0x100; head addr 0x100 appears one cycle after its push.
REQ-037 redirect to 0x102 -> misaligned_o 1, rd_o 0 indefinitely; later redirect to 0x200 -> misaligned_o 0, fetch resumes at 0x200.
REQ-038 ready_i random 50%, instr_ready_i random 50%, 1000 cycles -> consumed sequence equals memory model sequence from 0, count_o never > 4.
REQ-039 rst_i pulsed asynchronously mid-stream with count_o=3 -> outputs reset without clock edge; restart fetch at 0x0.
